// File: rtl/mod_inverse_fermat_pkg.sv
// Shared definitions for the MSM field-arithmetic slice: field width,
// prime modulus and the state encoding of the Fermat inverter FSM.
package elliptic_curve_structs;

  localparam int P_WIDTH = 8;
  localparam logic [P_WIDTH-1:0] P_MODULUS = 8'd101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SQ_ISS,
    SQ_WAIT,
    MU_ISS,
    MU_WAIT,
    FIN
  } inv_state_t;

endpackage

// File: rtl/mod_inverse_fermat.sv
// Modular inverse x^-1 mod P computed as x^(P-2) mod P with left-to-right
// square-and-multiply. All arithmetic is done by an external multi-cycle
// modular multiplier driven through mult_a/mult_b/mult_reset and read back
// on mult_done/mult_product.
// Optional build macro: MOD_INV_ZERO_BYPASS_EN (zero input skips the
// exponentiation and is flagged on zero_err).
module mod_inverse_fermat
  import elliptic_curve_structs::*;
#(
  parameter int               P_W     = P_WIDTH,
  parameter logic [P_W-1:0]   MODULUS = P_MODULUS
) (
  input  logic           clk,
  input  logic           Reset_n,
  input  logic           start,
  input  logic [P_W-1:0] x_in,
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] result,
  output logic [P_W-1:0] mult_a,
  output logic [P_W-1:0] mult_b,
  output logic           mult_reset,
  input  logic           mult_done,
  input  logic [P_W-1:0] mult_product
`ifdef MOD_INV_ZERO_BYPASS_EN
  ,
  output logic           zero_err
`endif
);

  localparam logic [P_W-1:0] EXP = MODULUS - P_W'(2);
  localparam int IW = (P_W > 1) ? $clog2(P_W) : 1;

  function automatic int unsigned top_bit(input logic [P_W-1:0] v);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < P_W; k++) begin
      if (v[k]) r = k;
    end
    return r;
  endfunction

  localparam int unsigned MSB    = top_bit(EXP);
  localparam logic [IW-1:0] MSB_M1 = IW'(MSB - 1);

  inv_state_t     state;
  logic [P_W-1:0] x_reg;
  logic [P_W-1:0] acc;
  logic [IW-1:0]  idx;

  // Inverter FSM: sequences squarings/multiplies over the exponent bits and
  // owns every registered output. While mult_reset is high the multiplier's
  // Done may still be the level left over from the previous op, so the wait
  // states only look at mult_done once mult_reset has dropped.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      mult_a     <= '0;
      mult_b     <= '0;
      mult_reset <= 1'b0;
      x_reg      <= '0;
      acc        <= '0;
      idx        <= '0;
`ifdef MOD_INV_ZERO_BYPASS_EN
      zero_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_reg <= x_in;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end

        LOAD: begin
          acc <= x_reg;
          idx <= MSB_M1;
`ifdef MOD_INV_ZERO_BYPASS_EN
          if (MSB == 0 || x_reg == '0) begin
            zero_err <= (x_reg == '0);
`else
          if (MSB == 0) begin
`endif
            result <= x_reg;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= FIN;
          end else begin
            state <= SQ_ISS;
          end
        end

        SQ_ISS: begin
          mult_a     <= acc;
          mult_b     <= acc;
          mult_reset <= 1'b1;
          state      <= SQ_WAIT;
        end

        SQ_WAIT: begin
          if (mult_reset) begin
            mult_reset <= 1'b0;
          end else if (mult_done) begin
            acc <= mult_product;
            if (EXP[idx]) begin
              state <= MU_ISS;
            end else if (idx == '0) begin
              result <= mult_product;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= FIN;
            end else begin
              idx   <= idx - 1'b1;
              state <= SQ_ISS;
            end
          end
        end

        MU_ISS: begin
          mult_a     <= acc;
          mult_b     <= x_reg;
          mult_reset <= 1'b1;
          state      <= MU_WAIT;
        end

        MU_WAIT: begin
          if (mult_reset) begin
            mult_reset <= 1'b0;
          end else if (mult_done) begin
            acc <= mult_product;
            if (idx == '0) begin
              result <= mult_product;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= FIN;
            end else begin
              idx   <= idx - 1'b1;
              state <= SQ_ISS;
            end
          end
        end

        FIN: begin
          done  <= 1'b0;
`ifdef MOD_INV_ZERO_BYPASS_EN
          zero_err <= 1'b0;
`endif
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inverse_fermat.sv
// Bench for mod_inverse_fermat (MODULUS=101, P_W=8) paired with a
// behavioural multiplier of configurable latency whose Done stays high
// between operations. Honours MOD_INV_ZERO_BYPASS_EN.
module tb_mod_inverse_fermat;

  localparam int P_W  = 8;
  localparam int MODV = 101;

  logic           clk = 1'b0;
  logic           Reset_n;
  logic           start;
  logic [P_W-1:0] x_in;
  logic           busy;
  logic           done;
  logic [P_W-1:0] result;
  logic [P_W-1:0] mult_a;
  logic [P_W-1:0] mult_b;
  logic           mult_reset;
  logic           mult_done = 1'b1;
  logic [P_W-1:0] mult_product = '0;
`ifdef MOD_INV_ZERO_BYPASS_EN
  logic           zero_err;
`endif

  int total = 0;
  int bad   = 0;
  int lat   = 4;
  int nops  = 0;
  int ndone = 0;

  int             mcnt = 0;
  logic           mbusy = 1'b0;
  logic [P_W-1:0] mprod = '0;

  always #5 clk = ~clk;

  mod_inverse_fermat #(.P_W(P_W), .MODULUS(8'd101)) dut (
    .clk          (clk),
    .Reset_n      (Reset_n),
    .start        (start),
    .x_in         (x_in),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_reset   (mult_reset),
    .mult_done    (mult_done),
    .mult_product (mult_product)
`ifdef MOD_INV_ZERO_BYPASS_EN
    ,
    .zero_err     (zero_err)
`endif
  );

  // Multiplier model: Done is cleared only at the launch edge, so it is
  // still stale-high during the mult_reset cycle; product bus is garbage
  // until Done rises.
  always @(posedge clk) begin
    if (mult_reset) begin
      mprod        <= P_W'((int'(mult_a) * int'(mult_b)) % MODV);
      mcnt         <= lat - 1;
      mbusy        <= 1'b1;
      mult_done    <= 1'b0;
      mult_product <= P_W'($urandom);
    end else if (mbusy) begin
      if (mcnt == 0) begin
        mult_done    <= 1'b1;
        mult_product <= mprod;
        mbusy        <= 1'b0;
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  // Event counters for launches and done pulses
  always @(posedge clk) begin
    if (mult_reset) nops  <= nops + 1;
    if (done)       ndone <= ndone + 1;
  end

  // Reference: x^(P-2) mod P by repeated multiplication
  function automatic int ref_pow(input int x);
    int r;
    r = 1;
    for (int k = 0; k < MODV - 2; k++) r = (r * x) % MODV;
    return r;
  endfunction

  // Reference op count: squarings = index of top bit, multiplies = popcount-1
  function automatic int ref_ops();
    int e, hi, pc;
    e = MODV - 2; hi = 0; pc = 0;
    for (int k = 0; k < 31; k++) begin
      if ((e >> k) & 1) begin
        hi = k;
        pc++;
      end
    end
    return hi + pc - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // One job, entered and left at a negedge; start is driven immediately.
  task automatic run_job(input int x, input int l, input bit poke_busy,
                         input bit poke_done, input string tag);
    int n0, d0, cyc, expv;
    bit got;
    lat  = l;
    expv = ref_pow(x);
    n0   = nops;
    d0   = ndone;
    start = 1'b1;
    x_in  = P_W'(x);
    @(negedge clk);
    start = 1'b0;
    x_in  = P_W'($urandom);
    chk({tag, "_busy_on"}, busy, 1);
    cyc = 1;
    got = 0;
    while (!got && cyc < 3000) begin
      if (done) begin
        got = 1;
      end else begin
        if (poke_busy && cyc == 15) begin
          start = 1'b1;
          x_in  = 8'd5;
        end
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_result"}, result, expv);
    if (x != 0) chk({tag, "_inverse"}, (x * int'(result)) % MODV, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
`ifdef MOD_INV_ZERO_BYPASS_EN
    if (x == 0) begin
      chk({tag, "_ops"}, nops - n0, 0);
      chk({tag, "_latency"}, cyc, 2);
      chk({tag, "_zero_err"}, zero_err, 1);
    end else begin
      chk({tag, "_ops"}, nops - n0, ref_ops());
      chk({tag, "_zero_err"}, zero_err, 0);
    end
`else
    chk({tag, "_ops"}, nops - n0, ref_ops());
`endif
    if (poke_done) begin
      start = 1'b1;
      x_in  = 8'd5;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_done_count"}, ndone - d0, 1);
    chk({tag, "_result_held"}, result, expv);
    if (poke_done) chk({tag, "_start_on_done_ignored"}, busy, 0);
  endtask

  initial begin
    int n0, d0, k, rx, rl;
    Reset_n = 1'b0;
    start   = 1'b0;
    x_in    = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    chk("rst_mult_reset", mult_reset, 0);
    @(negedge clk);
    @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);

    chk("ref_ops_is_9", ref_ops(), 9);
    run_job(2, 4, 0, 0, "x2");
    chk("x2_const", result, 51);
    run_job(3, 4, 0, 0, "x3");
    chk("x3_const", result, 34);
    run_job(100, 4, 0, 0, "x100");
    chk("x100_const", result, 100);
    run_job(1, 4, 0, 1, "x1");
    chk("x1_const", result, 1);
    run_job(2, 5, 1, 0, "x2_poke_busy");
    chk("x2_poke_busy_const", result, 51);
    run_job(2, 1, 0, 0, "x2_lat1");
    run_job(2, 12, 0, 0, "x2_lat12");

    // Abort during SQ_WAIT of the fourth op
    lat = 6;
    n0  = nops;
    d0  = ndone;
    start = 1'b1;
    x_in  = 8'd2;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while ((nops - n0) < 4 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reached_op4", ((nops - n0) >= 4) ? 1 : 0, 1);
    @(negedge clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_mult_a", mult_a, 0);
    chk("abort_mult_b", mult_b, 0);
    chk("abort_mult_reset", mult_reset, 0);
    @(negedge clk);
    Reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", ndone - d0, 0);
    chk("abort_idle", busy, 0);
    run_job(3, 6, 0, 0, "after_abort_x3");
    chk("after_abort_x3_const", result, 34);

    run_job(0, 3, 0, 0, "x0");
    chk("x0_const", result, 0);

    for (int j = 0; j < 8; j++) begin
      rx = int'($urandom_range(0, MODV - 1));
      rl = int'($urandom_range(1, 12));
      run_job(rx, rl, 0, 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
